// File: rtl/game_pkg.sv
// Shared constants, button index names and button FSM encoding for the count game front end.
package game_pkg;

  localparam int DEB_CYC_DEF  = 20000;
  localparam int LONG_CYC_DEF = 1000000;

  localparam int BTN_START = 0;
  localparam int BTN_RST   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PWAIT = 2'd1,
    HELD  = 2'd2,
    RWAIT = 2'd3
  } btn_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One push button: 2-FF synchroniser, debounce counter, press/release FSM and long-press hold counter.
module debounce_cell
  import game_pkg::*;
#(
  parameter int DEB_CYC  = DEB_CYC_DEF,
  parameter int LONG_CYC = LONG_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_press
);

  localparam int DW = cnt_width(DEB_CYC);
  localparam int LW = cnt_width(LONG_CYC);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);

  logic          sync1;
  logic          s;
  logic [DW-1:0] cnt;
  logic [LW-1:0] hold;
  logic          long_done;
  btn_state_t    state;

  logic deb_done;
  logic holding;
  assign deb_done = (cnt == DEB_LAST);
  assign holding  = (state == HELD) || (state == RWAIT);

  // long_done blocks a second btn_long because the saturated hold counter keeps matching LONG_LAST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b0;
      s          <= 1'b0;
      cnt        <= '0;
      hold       <= '0;
      long_done  <= 1'b0;
      state      <= IDLE;
      level      <= 1'b0;
      press      <= 1'b0;
      rel        <= 1'b0;
      long_press <= 1'b0;
    end else begin
      sync1      <= raw;
      s          <= sync1;
      press      <= 1'b0;
      rel        <= 1'b0;
      long_press <= 1'b0;

      if (s != level) begin
        if (deb_done) cnt <= '0;
        else          cnt <= cnt + DW'(1);
      end else begin
        cnt <= '0;
      end

      if (holding) begin
        if (hold != LONG_LAST) hold <= hold + LW'(1);
        if (hold == LONG_LAST && !long_done) begin
          long_press <= 1'b1;
          long_done  <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (s) begin
            if (deb_done) begin
              state     <= HELD;
              level     <= 1'b1;
              press     <= 1'b1;
              hold      <= '0;
              long_done <= 1'b0;
            end else begin
              state <= PWAIT;
            end
          end
        end
        PWAIT: begin
          if (!s) begin
            state <= IDLE;
          end else if (deb_done) begin
            state     <= HELD;
            level     <= 1'b1;
            press     <= 1'b1;
            hold      <= '0;
            long_done <= 1'b0;
          end
        end
        HELD: begin
          if (!s) begin
            if (deb_done) begin
              state <= IDLE;
              level <= 1'b0;
              rel   <= 1'b1;
            end else begin
              state <= RWAIT;
            end
          end
        end
        RWAIT: begin
          if (s) begin
            state <= HELD;
          end else if (deb_done) begin
            state <= IDLE;
            level <= 1'b0;
            rel   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: per-button debounce cells plus a debounced switch word with change strobe.
module input_conditioner
  import game_pkg::*;
#(
  parameter int NBTN     = 2,
  parameter int NSW      = 8,
  parameter int DEB_CYC  = DEB_CYC_DEF,
  parameter int LONG_CYC = LONG_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_in,
  input  logic [NSW-1:0]  sw_in,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_rel,
  output logic [NBTN-1:0] btn_long,
  output logic [NSW-1:0]  sw_stable,
  output logic            sw_chg
);

  localparam int DW = cnt_width(DEB_CYC);
  localparam logic [DW-1:0] SW_LAST = (DEB_CYC > 1) ? DW'(DEB_CYC - 2) : '0;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    debounce_cell #(
      .DEB_CYC  (DEB_CYC),
      .LONG_CYC (LONG_CYC)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .raw        (btn_in[i]),
      .level      (btn_level[i]),
      .press      (btn_press[i]),
      .rel        (btn_rel[i]),
      .long_press (btn_long[i])
    );
  end

  logic [NSW-1:0] sw_sync1;
  logic [NSW-1:0] sw_s;
  logic [NSW-1:0] sw_prev;
  logic [DW-1:0]  sw_cnt;
  logic           sw_settled;

  // sw_cnt counts cycles beyond the first that sw_s has held, so it matches SW_LAST after DEB_CYC stable cycles
  assign sw_settled = (DEB_CYC <= 1) ? 1'b1 : ((sw_s == sw_prev) && (sw_cnt == SW_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync1  <= '0;
      sw_s      <= '0;
      sw_prev   <= '0;
      sw_cnt    <= '0;
      sw_stable <= '0;
      sw_chg    <= 1'b0;
    end else begin
      sw_sync1 <= sw_in;
      sw_s     <= sw_sync1;
      sw_prev  <= sw_s;
      sw_chg   <= 1'b0;

      if (sw_s != sw_prev)        sw_cnt <= '0;
      else if (sw_cnt != SW_LAST) sw_cnt <= sw_cnt + DW'(1);

      if (sw_settled && (sw_s != sw_stable)) begin
        sw_stable <= sw_s;
        sw_chg    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce and long-press windows.
module tb_input_conditioner;
  import game_pkg::*;

  localparam int NBTN = 2;
  localparam int NSW  = 8;
  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NBTN-1:0] btn_in;
  logic [NSW-1:0]  sw_in;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_press;
  logic [NBTN-1:0] btn_rel;
  logic [NBTN-1:0] btn_long;
  logic [NSW-1:0]  sw_stable;
  logic            sw_chg;

  int errors = 0;
  int checks = 0;
  int press_cnt [NBTN];
  int rel_cnt   [NBTN];
  int long_cnt  [NBTN];
  int chg_cnt;

  always #5 clk = ~clk;

  input_conditioner #(
    .NBTN     (NBTN),
    .NSW      (NSW),
    .DEB_CYC  (DEB),
    .LONG_CYC (LONG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .sw_in     (sw_in),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .btn_rel   (btn_rel),
    .btn_long  (btn_long),
    .sw_stable (sw_stable),
    .sw_chg    (sw_chg)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NBTN-1:0] b, input logic [NSW-1:0] s);
    btn_in = b;
    sw_in  = s;
  endtask

  // Each tick ends 1 time unit after a rising edge; inputs change and outputs are sampled there
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      for (int b = 0; b < NBTN; b++) begin
        press_cnt[b] += int'(btn_press[b]);
        rel_cnt[b]   += int'(btn_rel[b]);
        long_cnt[b]  += int'(btn_long[b]);
      end
      chg_cnt += int'(sw_chg);
    end
  endtask

  task automatic clear_counts();
    for (int b = 0; b < NBTN; b++) begin
      press_cnt[b] = 0;
      rel_cnt[b]   = 0;
      long_cnt[b]  = 0;
    end
    chg_cnt = 0;
  endtask

  initial begin
    $display("[TB] start");
    clear_counts();
    rst = 1'b1;
    applyStimulus(2'b11, 8'hFF);
    tick(3);
    checkOutput("rst_btn", {btn_level, btn_press, btn_rel, btn_long}, 32'h0);
    checkOutput("rst_sw", {sw_stable, sw_chg}, 32'h0);

    rst = 1'b0;
    clear_counts();
    tick(5);
    checkOutput("t1_press_early", btn_press, 32'h0);
    tick(1);
    checkOutput("t1_press", btn_press, 32'h3);
    checkOutput("t1_level", btn_level, 32'h3);
    checkOutput("t1_sw_stable", sw_stable, 32'hFF);
    checkOutput("t1_sw_chg", sw_chg, 32'h1);
    tick(1);
    checkOutput("t1_press_gone", {btn_press, sw_chg}, 32'h0);
    applyStimulus(2'b00, 8'hFF);
    tick(10);
    checkOutput("t1_rel_level", btn_level, 32'h0);
    checkOutput("t1_rel_cnt0", rel_cnt[BTN_START], 32'd1);
    checkOutput("t1_rel_cnt1", rel_cnt[BTN_RST], 32'd1);

    // Short pulse is rejected, longer one is accepted with fixed latency
    clear_counts();
    applyStimulus(2'b01, 8'hFF);
    tick(3);
    applyStimulus(2'b00, 8'hFF);
    tick(10);
    checkOutput("t2_short_press", press_cnt[BTN_START], 32'd0);
    checkOutput("t2_short_level", btn_level, 32'h0);
    applyStimulus(2'b01, 8'hFF);
    tick(5);
    checkOutput("t2_press_early", btn_press, 32'h0);
    tick(1);
    checkOutput("t2_press", btn_press, 32'h1);
    applyStimulus(2'b00, 8'hFF);
    tick(5);
    checkOutput("t2_rel_early", btn_rel, 32'h0);
    tick(1);
    checkOutput("t2_rel", btn_rel, 32'h1);
    checkOutput("t2_rel_level", btn_level, 32'h0);
    tick(4);

    // Bouncy press yields a single event timed from the last rising edge
    clear_counts();
    applyStimulus(2'b01, 8'hFF); tick(1);
    applyStimulus(2'b00, 8'hFF); tick(1);
    applyStimulus(2'b01, 8'hFF); tick(1);
    applyStimulus(2'b00, 8'hFF); tick(1);
    applyStimulus(2'b01, 8'hFF);
    tick(5);
    checkOutput("t3_press_early", press_cnt[BTN_START], 32'd0);
    tick(1);
    checkOutput("t3_press", btn_press, 32'h1);
    tick(10);
    checkOutput("t3_press_once", press_cnt[BTN_START], 32'd1);
    applyStimulus(2'b00, 8'hFF);
    tick(10);

    // Long press on the restart button
    clear_counts();
    applyStimulus(2'b10, 8'hFF);
    tick(6);
    checkOutput("t4_press", btn_press, 32'h2);
    tick(15);
    checkOutput("t4_long_early", long_cnt[BTN_RST], 32'd0);
    tick(1);
    checkOutput("t4_long", btn_long, 32'h2);
    tick(18);
    applyStimulus(2'b00, 8'hFF);
    tick(6);
    checkOutput("t4_rel", btn_rel, 32'h2);
    tick(10);
    checkOutput("t4_long_once", long_cnt[BTN_RST], 32'd1);
    checkOutput("t4_press_once", press_cnt[BTN_RST], 32'd1);

    // Switch word ramps one bit per cycle, then a short glitch back to the same word
    applyStimulus(2'b00, 8'h00);
    tick(10);
    checkOutput("t5_sw_zero", sw_stable, 32'h00);
    clear_counts();
    applyStimulus(2'b00, 8'h01); tick(1);
    applyStimulus(2'b00, 8'h03); tick(1);
    applyStimulus(2'b00, 8'h07); tick(1);
    applyStimulus(2'b00, 8'h0F); tick(1);
    applyStimulus(2'b00, 8'h1F);
    tick(5);
    checkOutput("t5_chg_early", chg_cnt, 32'd0);
    tick(1);
    checkOutput("t5_chg", sw_chg, 32'h1);
    checkOutput("t5_sw_stable", sw_stable, 32'h1F);
    tick(10);
    checkOutput("t5_chg_once", chg_cnt, 32'd1);
    clear_counts();
    applyStimulus(2'b00, 8'h1B);
    tick(2);
    applyStimulus(2'b00, 8'h1F);
    tick(12);
    checkOutput("t5_glitch_chg", chg_cnt, 32'd0);
    checkOutput("t5_glitch_sw", sw_stable, 32'h1F);

    // Reset in the middle of a debounce discards the partial count
    clear_counts();
    applyStimulus(2'b01, 8'h1F);
    tick(2);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_sw", sw_stable, 32'h0);
    checkOutput("t6_rst_btn", {btn_level, btn_press}, 32'h0);
    tick(2);
    rst = 1'b0;
    clear_counts();
    tick(5);
    checkOutput("t6_press_early", press_cnt[BTN_START], 32'd0);
    tick(1);
    checkOutput("t6_press", btn_press, 32'h1);
    tick(10);
    checkOutput("t6_press_once", press_cnt[BTN_START], 32'd1);
    checkOutput("t6_sw_reload", sw_stable, 32'h1F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
